regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-port general-purpose register file for the pipeline core. It provides N independent combinational read ports and M synchronous write ports. A built-in per-register scoreboard (pending bits) lets decode detect RAW hazards against in-flight producers. It sits between decode (read, reserve) and writeback (write, release).

Parameters:
DATA_W, 32, register width in bits
REG_NUM, 32, number of registers (power of two, >=2)
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
AW, $clog2(REG_NUM), address width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
rd_en  in  NUM_RD  per-port read enable
rd_addr  in  NUM_RD*AW  read addresses; port i uses slice [i*AW +: AW]
rd_data  out  NUM_RD*DATA_W  read data, port i in slice [i*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  register addressed by port i has a pending producer
wr_en  in  NUM_WR  per-port write enable
wr_addr  in  NUM_WR*AW  write addresses
wr_data  in  NUM_WR*DATA_W  write data
rsv_en  in  1  reserve request (mark destination pending)
rsv_addr  in  AW  register to reserve
rsv_ok  out  1  reservation accepted this cycle

Behaviour:
- Reset (rst=0, asynchronous): all registers cleared to 0 and all pending bits cleared. While rst=0, rd_data=0, rd_busy=0 and rsv_ok=0. Reset asserted mid-operation discards all in-flight reservations.
- Write: when wr_en[j]=1, regs[wr_addr[j]] <= wr_data[j] on the rising edge. The write is visible on a read one cycle later.
- Write collision: if two or more write ports target the same address in one cycle, the highest-index port wins. No error is flagged.
- Read: combinational, zero latency.
  - rd_en[i]=0 -> rd_data slice = 0 and rd_busy[i]=0.
  - rd_en[i]=1 -> rd_data = regs[rd_addr[i]] and rd_busy[i] = pending[rd_addr[i]].
- Scoreboard, per-register pending bit:
  - Set: rsv_en=1 and rsv_ok=1 sets pending[rsv_addr] at the edge.
  - Clear: any wr_en[j]=1 clears pending[wr_addr[j]] at the edge.
  - Same address set and clear in one cycle: the set wins, because a new producer has been issued.
  - rsv_ok = rsv_en & ~pending[rsv_addr]. Reserving an already-pending register is refused (WAW stall) and its pending bit is unchanged.
- Writes to a non-pending register are legal and simply update data. Pending stays 0.
- Reads of any address, including during a same-cycle write, never stall. Stalling is decode's decision based on rd_busy.
- Register 0 is an ordinary register with no hardwired zero.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: the read path forwards same-cycle write data. If rd_en[i]=1 and some wr_en[j]=1 with wr_addr[j]==rd_addr[i]:
  - rd_data takes wr_data from the highest matching j.
  - rd_busy[i] is forced to 0, unless rsv_en=1 and rsv_ok=1 to the same address that cycle, in which case it is 1.
- Undefined: the read returns the pre-edge array value and the current pending bit. Write-to-read latency is 1 cycle.

Decomposition:
- Package regfile_pkg holds:
  - default constants DATA_W_DEF, REG_NUM_DEF, NUM_RD_DEF, NUM_WR_DEF
  - typedef reg_addr_t (logic [AW-1:0]) and reg_data_t (logic [DATA_W-1:0])
  - constant ZERO_WORD
- One natural sub-module: regfile_scoreboard. It holds the pending-bit vector plus set/clear priority, and produces rsv_ok and per-address busy lookup.
- The data array and bypass mux stay in regfile_mp.

Test Plan:
1. Reset then read: hold rst=0, then release. Read r5 on both ports with rd_en=11 -> rd_data=0, rd_busy=00. Assert rst=0 asynchronously between edges -> outputs go to 0 immediately.
2. Write/read latency: wr_en[0]=1, addr=3, data=0xDEADBEEF. Same-cycle read of r3 returns 0 (bypass off) or 0xDEADBEEF (bypass on). The next cycle returns 0xDEADBEEF in both builds.
3. Write collision: port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle -> the next read of r7 = 0x22.
4. Scoreboard: rsv r9 -> rsv_ok=1 and the next-cycle read of r9 shows rd_busy=1. A second rsv of r9 -> rsv_ok=0. Write r9=0x55 -> the next cycle shows busy=0 and data 0x55.
5. Set/clear race: with r4 pending, write r4 and reserve r4 in the same cycle -> rsv_ok=0 (already pending). Retry the next cycle -> rsv_ok=1 and r4 busy stays 1. Fresh case: write and reserve r6 together with r6 idle -> pending[6]=1 afterwards.
6. Mid-operation reset: reserve r1 and r2, write r1=0xAB, assert rst=0 -> all pending bits cleared, all data 0, and reserving r1 after release returns rsv_ok=1.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned REG_NUM_DEF = 32;
  localparam int unsigned NUM_RD_DEF  = 2;
  localparam int unsigned NUM_WR_DEF  = 2;
  localparam int unsigned AW_DEF      = $clog2(REG_NUM_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam reg_data_t ZERO_WORD = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports and the
// reservation request. Ports are flattened; port i sits in slice [i*W +: W].
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned NUM_RD  = NUM_RD_DEF,
  parameter int unsigned NUM_WR  = NUM_WR_DEF
);
  localparam int unsigned AW = $clog2(REG_NUM);

  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     rsv_ok;

  // Pipeline side (decode + writeback).
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data, rd_busy, rsv_ok
  );

  // Register file side.
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data, rd_busy, rsv_ok
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for RAW/WAW hazard detection. A reservation sets
// a bit, any write to that register clears it; a same-cycle set beats the
// clear because it represents a newly issued producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned NUM_RD  = NUM_RD_DEF,
  parameter int unsigned NUM_WR  = NUM_WR_DEF,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic                 rsv_ok,
  output logic [NUM_RD-1:0]    rd_pend
);

  logic [REG_NUM-1:0] pending_q, pending_d;

  // Refuse reservations of an already-pending register and while in reset.
  always_comb begin
    rsv_ok = rst & rsv_en & ~pending_q[rsv_addr];
  end

  // Clears first, then the reservation, so the set wins on an address match.
  always_comb begin
    pending_d = pending_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (wr_en[j]) begin
        pending_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
    end
    if (rsv_ok) begin
      pending_d[rsv_addr] = 1'b1;
    end
  end

  // Pending-bit state, discarded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Busy lookup for each read port.
  always_comb begin
    rd_pend = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_pend[i] = pending_q[rd_addr[i*AW +: AW]];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with hazard scoreboard.
// NUM_RD combinational read ports, NUM_WR synchronous write ports; on a write
// address collision the highest-index port wins. Register 0 is ordinary.
// Optional: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned REG_NUM = REG_NUM_DEF,
  parameter int unsigned NUM_RD  = NUM_RD_DEF,
  parameter int unsigned NUM_WR  = NUM_WR_DEF,
  localparam int unsigned AW     = $clog2(REG_NUM)
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] regs_d [REG_NUM];
  logic [NUM_RD-1:0] rd_pend;
  logic              rsv_ok;

  regfile_scoreboard #(
    .REG_NUM (REG_NUM),
    .NUM_RD  (NUM_RD),
    .NUM_WR  (NUM_WR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (bus.wr_en),
    .wr_addr  (bus.wr_addr),
    .rsv_en   (bus.rsv_en),
    .rsv_addr (bus.rsv_addr),
    .rd_addr  (bus.rd_addr),
    .rsv_ok   (rsv_ok),
    .rd_pend  (rd_pend)
  );

  assign bus.rsv_ok = rsv_ok;

  // Next array contents; ascending port order lets the highest port win.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NUM_WR; j++) begin
      if (bus.wr_en[j]) begin
        regs_d[bus.wr_addr[j*AW +: AW]] = bus.wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  // Register array, cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports; disabled ports and reset force zeros.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst && bus.rd_en[i]) begin
        bus.rd_data[i*DATA_W +: DATA_W] = regs_q[bus.rd_addr[i*AW +: AW]];
        bus.rd_busy[i] = rd_pend[i];
`ifdef REGFILE_BYPASS_EN
        for (int j = 0; j < NUM_WR; j++) begin
          if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == bus.rd_addr[i*AW +: AW])) begin
            bus.rd_data[i*DATA_W +: DATA_W] = bus.wr_data[j*DATA_W +: DATA_W];
            // Producer lands this edge; only a fresh reservation keeps it busy.
            bus.rd_busy[i] = rsv_ok && (bus.rsv_addr == bus.rd_addr[i*AW +: AW]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: the driver pushes expected outputs into a
// queue as it applies stimulus; a monitor pops and compares on the falling edge.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int unsigned AW = AW_DEF;
  localparam int unsigned DW = DATA_W_DEF;

  typedef struct {
    string       name;
    int          kind;  // 0 rd_data[port], 1 rd_busy vector, 2 rsv_ok
    int          port;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   checks;
  int   failures;

  regfile_mp_if bus ();

  regfile_mp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are combinational, so every queued expectation applies
  // to the inputs currently driven.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = bus.rd_data[e.port*DW +: DW];
        1:       act = {30'd0, bus.rd_busy};
        default: act = {31'd0, bus.rsv_ok};
      endcase
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  task automatic push(input string name, input int kind, input int port, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.kind = kind;
    e.port = port;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    bus.rd_en    = '0;
    bus.rd_addr  = '0;
    bus.wr_en    = '0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rsv_en   = 1'b0;
    bus.rsv_addr = '0;
  endtask

  // Start a new cycle: just after the rising edge, all enables cleared.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input int port, input int addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    bus.rd_en[port] = 1'b1;
    bus.rd_addr[port*AW +: AW] = a;
  endtask

  task automatic wr(input int port, input int addr, input logic [31:0] d);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    bus.wr_en[port] = 1'b1;
    bus.wr_addr[port*AW +: AW] = a;
    bus.wr_data[port*DW +: DW] = d;
  endtask

  task automatic rsv(input int addr);
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    bus.rsv_en   = 1'b1;
    bus.rsv_addr = a;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    idle();

    // 1. Reset: outputs held at zero, reservations refused.
    cyc();
    rd(0, 5); rd(1, 5); rsv(5);
    push("rst_rd0", 0, 0, 32'h0);
    push("rst_rd1", 0, 1, 32'h0);
    push("rst_busy", 1, 0, 32'h0);
    push("rst_rsv_ok", 2, 0, 32'h0);
    cyc();
    rst = 1'b1;
    rd(0, 5); rd(1, 5);
    push("post_rst_rd0", 0, 0, 32'h0);
    push("post_rst_busy", 1, 0, 32'h0);

    // 2. Write/read latency.
    cyc();
    wr(0, 3, 32'hDEADBEEF); rd(0, 3);
`ifdef REGFILE_BYPASS_EN
    push("same_cyc_r3", 0, 0, 32'hDEADBEEF);
`else
    push("same_cyc_r3", 0, 0, 32'h0);
`endif
    push("same_cyc_busy", 1, 0, 32'h0);
    cyc();
    rd(0, 3);
    push("next_cyc_r3", 0, 0, 32'hDEADBEEF);

    // 3. Write collision: port 1 wins.
    cyc();
    wr(0, 7, 32'h11); wr(1, 7, 32'h22);
    cyc();
    rd(1, 7); rd(0, 3);
    push("collide_r7", 0, 1, 32'h22);
    push("indep_r3", 0, 0, 32'hDEADBEEF);

    // 4. Scoreboard reserve / WAW refusal / release.
    cyc();
    rsv(9);
    push("rsv9_ok", 2, 0, 32'h1);
    cyc();
    rd(0, 9); rsv(9);
    push("r9_busy", 1, 0, 32'h1);
    push("rsv9_again", 2, 0, 32'h0);
    cyc();
    wr(1, 9, 32'h55);
    cyc();
    rd(0, 9);
    push("r9_released", 1, 0, 32'h0);
    push("r9_data", 0, 0, 32'h55);

    // 5. Set/clear race.
    cyc();
    rsv(4);
    push("rsv4_ok", 2, 0, 32'h1);
    cyc();
    wr(0, 4, 32'h44); rsv(4);
    push("rsv4_pending", 2, 0, 32'h0);
    cyc();
    rsv(4);
    push("rsv4_retry", 2, 0, 32'h1);
    cyc();
    rd(0, 4);
    push("r4_busy", 1, 0, 32'h1);
    push("r4_data", 0, 0, 32'h44);
    cyc();
    wr(1, 6, 32'h66); rsv(6);
    push("rsv6_ok", 2, 0, 32'h1);
    cyc();
    rd(1, 6);
    push("r6_set_wins", 1, 0, 32'h2);
    push("r6_data", 0, 1, 32'h66);

    // 6. Mid-operation reset.
    cyc();
    rsv(1);
    push("rsv1_ok", 2, 0, 32'h1);
    cyc();
    rsv(2);
    push("rsv2_ok", 2, 0, 32'h1);
    cyc();
    wr(0, 1, 32'hAB);
    cyc();
    rd(0, 1); rd(1, 2);
    push("r1_data", 0, 0, 32'hAB);
    push("r1r2_busy", 1, 0, 32'h2);
    cyc();
    rd(0, 1); rd(1, 2); rsv(3);
    #1;
    rst = 1'b0;  // asserted between edges
    push("async_rst_r1", 0, 0, 32'h0);
    push("async_rst_busy", 1, 0, 32'h0);
    push("async_rst_rsv", 2, 0, 32'h0);
    cyc();
    rst = 1'b1;
    rsv(1); rd(0, 1); rd(1, 2);
    push("rsv1_after_rst", 2, 0, 32'h1);
    push("r1_cleared", 0, 0, 32'h0);
    push("r2_unpend", 1, 0, 32'h0);
    cyc();
    rd(0, 7); rd(1, 3);
    push("r7_cleared", 0, 0, 32'h0);
    push("r3_cleared", 0, 1, 32'h0);

    cyc();
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
